// File: rtl/tx_cordic_upconverter.sv
// tx_cordic_upconverter: transmit-side CORDIC upconverter.
// Rotates baseband (I, Q) by a free-running 32-bit NCO phase and emits the
// rounded, saturated real part as a DAC word, one sample per clock.
// Optional build macro: TX_CORDIC_GAIN_COMP_EN adds a registered
// 19898/32768 gain-compensation multiply (unity gain, one extra edge).
module tx_cordic_upconverter #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 14,
  parameter int STG       = 18
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [31:0]                 frequency,
  input  logic                        phase_sync,
  input  logic signed [IN_WIDTH-1:0]  in_I,
  input  logic signed [IN_WIDTH-1:0]  in_Q,
  input  logic                        in_valid,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic                        out_valid
);
  localparam int WR  = IN_WIDTH + 2;
  localparam int WZ  = STG + 2;
  localparam int OSH = WR - OUT_WIDTH - 1;
`ifdef TX_CORDIC_GAIN_COMP_EN
  localparam int SW  = WR + 16;
  localparam int SH  = OSH + 15;
  localparam int LAT = STG + 3;
  localparam logic signed [SW-1:0] GC = SW'(19898);
`else
  localparam int SW  = WR;
  localparam int SH  = OSH;
  localparam int LAT = STG + 2;
`endif
  localparam logic signed [SW:0] RND  = (SW + 1)'(1) << (SH - 1);
  localparam logic signed [SW:0] MAXV = (SW + 1)'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [SW:0] MINV = ~MAXV;

  // atan(2^-i) on the NCO scale (2^32 == 2*pi)
  function automatic logic [31:0] atan32(input int i);
    case (i)
      0:  return 32'd536870912;
      1:  return 32'd316933406;
      2:  return 32'd167458907;
      3:  return 32'd85004756;
      4:  return 32'd42667331;
      5:  return 32'd21354465;
      6:  return 32'd10679838;
      7:  return 32'd5340245;
      8:  return 32'd2670163;
      9:  return 32'd1335087;
      10: return 32'd667544;
      11: return 32'd333772;
      12: return 32'd166886;
      13: return 32'd83443;
      14: return 32'd41722;
      15: return 32'd20861;
      16: return 32'd10430;
      17: return 32'd5215;
      18: return 32'd2608;
      19: return 32'd1304;
      20: return 32'd652;
      21: return 32'd326;
      22: return 32'd163;
      23: return 32'd81;
      24: return 32'd41;
      25: return 32'd20;
      26: return 32'd10;
      27: return 32'd5;
      default: return 32'd3;
    endcase
  endfunction

  // Residual-angle LSB weighs 2^(30-WZ) NCO units; round to that grid.
  // The i=0 constant (pi/4) wraps to -2^(WZ-1), which is harmless in the
  // modular Z arithmetic since the result always lands in range.
  function automatic logic [WZ-1:0] atan_z(input int i);
    logic [32:0] t;
    t = ({1'b0, atan32(i)} + (33'd1 << (29 - WZ))) >> (30 - WZ);
    return t[WZ-1:0];
  endfunction

  // Arithmetic shift right with round-half-up (adds the last bit shifted out)
  function automatic logic signed [WR-1:0] rshift(input logic signed [WR-1:0] v, input int sh);
    logic signed [WR-1:0] t;
    t = v >>> sh;
    if (sh > 0) t = t + {{(WR - 1){1'b0}}, v[sh-1]};
    return t;
  endfunction

  logic [31:0]                 phase_q, phase_d;
  logic signed [IN_WIDTH-1:0]  cap_i_q, cap_i_d, cap_q_q, cap_q_d;
  logic [WZ+1:0]               cap_ph_q, cap_ph_d;
  logic [LAT:0]                vld_q, vld_d;
  logic signed [WR-1:0]        x_q [0:STG];
  logic signed [WR-1:0]        x_d [0:STG];
  logic signed [WR-1:0]        y_q [0:STG];
  logic signed [WR-1:0]        y_d [0:STG];
  logic [WZ-1:0]               z_q [0:STG];
  logic [WZ-1:0]               z_d [0:STG];
  logic signed [WR-1:0]        fold_i, fold_q;
  logic [1:0]                  quad;
  logic signed [SW-1:0]        scaled;
  logic signed [SW:0]          rsum, rq;
  logic signed [OUT_WIDTH-1:0] out_q, out_d;
`ifdef TX_CORDIC_GAIN_COMP_EN
  logic signed [SW-1:0]        prod_q, prod_d;
`endif

  // NCO update, gated input capture (with pre-update phase) and valid shift
  always_comb begin
    phase_d  = phase_sync ? 32'd0 : phase_q + frequency;
    cap_i_d  = in_valid ? in_I : '0;
    cap_q_d  = in_valid ? in_Q : '0;
    cap_ph_d = phase_q[31 -: WZ + 2];
    vld_d    = {vld_q[LAT-1:0], in_valid};
  end

  // Quadrant fold into [-pi/4, pi/4) followed by the micro-rotation stages
  always_comb begin
    x_d    = '{default: '0};
    y_d    = '{default: '0};
    z_d    = '{default: '0};
    fold_i = {{(WR - IN_WIDTH){cap_i_q[IN_WIDTH-1]}}, cap_i_q};
    fold_q = {{(WR - IN_WIDTH){cap_q_q[IN_WIDTH-1]}}, cap_q_q};
    quad   = cap_ph_q[WZ+1:WZ] + {1'b0, cap_ph_q[WZ-1]};
    case (quad)
      2'd0:    begin x_d[0] = fold_i;  y_d[0] = fold_q;  end
      2'd1:    begin x_d[0] = -fold_q; y_d[0] = fold_i;  end
      2'd2:    begin x_d[0] = -fold_i; y_d[0] = -fold_q; end
      default: begin x_d[0] = fold_q;  y_d[0] = -fold_i; end
    endcase
    z_d[0] = cap_ph_q[WZ-1:0];
    for (int i = 0; i < STG; i++) begin
      logic signed [WR-1:0] dx, dy;
      dx = rshift(x_q[i], i);
      dy = rshift(y_q[i], i);
      if (!z_q[i][WZ-1]) begin
        x_d[i+1] = x_q[i] - dy;
        y_d[i+1] = y_q[i] + dx;
        z_d[i+1] = z_q[i] - atan_z(i);
      end else begin
        x_d[i+1] = x_q[i] + dy;
        y_d[i+1] = y_q[i] - dx;
        z_d[i+1] = z_q[i] + atan_z(i);
      end
    end
  end

  // Optional gain compensation, then round-half-up and saturate to the DAC width
  always_comb begin
`ifdef TX_CORDIC_GAIN_COMP_EN
    prod_d = $signed({{(SW - WR){x_q[STG][WR-1]}}, x_q[STG]}) * GC;
    scaled = prod_q;
`else
    scaled = x_q[STG];
`endif
    rsum = {scaled[SW-1], scaled} + RND;
    rq   = rsum >>> SH;
    if (rq > MAXV)      out_d = MAXV[OUT_WIDTH-1:0];
    else if (rq < MINV) out_d = MINV[OUT_WIDTH-1:0];
    else                out_d = rq[OUT_WIDTH-1:0];
  end

  // Pipeline registers; reset clears every stage so in-flight samples vanish
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase_q  <= '0;
      cap_i_q  <= '0;
      cap_q_q  <= '0;
      cap_ph_q <= '0;
      vld_q    <= '0;
      x_q      <= '{default: '0};
      y_q      <= '{default: '0};
      z_q      <= '{default: '0};
      out_q    <= '0;
`ifdef TX_CORDIC_GAIN_COMP_EN
      prod_q   <= '0;
`endif
    end else begin
      phase_q  <= phase_d;
      cap_i_q  <= cap_i_d;
      cap_q_q  <= cap_q_d;
      cap_ph_q <= cap_ph_d;
      vld_q    <= vld_d;
      x_q      <= x_d;
      y_q      <= y_d;
      z_q      <= z_d;
      out_q    <= out_d;
`ifdef TX_CORDIC_GAIN_COMP_EN
      prod_q   <= prod_d;
`endif
    end
  end

  assign out_data  = out_q;
  assign out_valid = vld_q[LAT];

endmodule

// File: tb/tb_tx_cordic_upconverter.sv
// Scoreboard bench for tx_cordic_upconverter: the driver predicts each
// output from an ideal rotation (cos/sin of the NCO phase) and queues it
// with its due cycle; an independent monitor compares on every clock.
module tb_tx_cordic_upconverter;
  localparam int IN_WIDTH  = 16;
  localparam int OUT_WIDTH = 14;
  localparam int STG       = 18;
`ifdef TX_CORDIC_GAIN_COMP_EN
  localparam int  LAT  = STG + 3;
  localparam real GAIN = 1.6467602581 * 19898.0 / 32768.0;
`else
  localparam int  LAT  = STG + 2;
  localparam real GAIN = 1.6467602581;
`endif
  localparam real TWO_PI = 6.283185307179586;

  logic                        clock;
  logic                        reset_n;
  logic [31:0]                 frequency;
  logic                        phase_sync;
  logic signed [IN_WIDTH-1:0]  in_I, in_Q;
  logic                        in_valid;
  logic signed [OUT_WIDTH-1:0] out_data;
  logic                        out_valid;

  typedef struct {
    int  due;
    bit  vld;
    real ideal;
  } exp_t;

  exp_t        sb[$];
  exp_t        me;
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  logic [31:0] model_phase = 32'd0;

  tx_cordic_upconverter #(
    .IN_WIDTH (IN_WIDTH),
    .OUT_WIDTH(OUT_WIDTH),
    .STG      (STG)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .frequency (frequency),
    .phase_sync(phase_sync),
    .in_I      (in_I),
    .in_Q      (in_Q),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Issue one input slot and queue its predicted output
  task automatic drive(input bit v, input int iv, input int qv, input bit sync, input logic [31:0] freq);
    exp_t e;
    real  th, r;
    @(negedge clock);
    in_valid   = v;
    in_I       = IN_WIDTH'(iv);
    in_Q       = IN_WIDTH'(qv);
    phase_sync = sync;
    frequency  = freq;
    th = TWO_PI * real'(model_phase) / 4294967296.0;
    r  = GAIN * (real'(iv) * $cos(th) - real'(qv) * $sin(th)) / 8.0;
    if (r > 8191.0)  r = 8191.0;
    if (r < -8192.0) r = -8192.0;
    e.due   = cyc + 1 + LAT;
    e.vld   = v;
    e.ideal = v ? r : 0.0;
    sb.push_back(e);
    model_phase = sync ? 32'd0 : model_phase + freq;
  endtask

  task automatic check_eq(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Assert reset mid-stream with valid data present, then release cleanly
  task automatic reset_midstream();
    @(negedge clock);
    reset_n  = 1'b0;
    in_valid = 1'b1;
    in_I     = 16'sd16384;
    sb.delete();
    model_phase = 32'd0;
    #1;
    check_eq("reset_immediate_valid", int'(out_valid), 0);
    check_eq("reset_immediate_data", int'(out_data), 0);
    repeat (3) @(negedge clock);
    check_eq("reset_hold_valid", int'(out_valid), 0);
    check_eq("reset_hold_data", int'(out_data), 0);
    in_valid   = 1'b0;
    phase_sync = 1'b0;
    frequency  = 32'd0;
    reset_n    = 1'b1;
  endtask

  // Monitor: compare whatever is due this cycle; otherwise nothing may be valid
  always @(negedge clock) begin
    if (reset_n) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        real diff;
        me = sb.pop_front();
        checks++;
        if (out_valid !== me.vld) begin
          errors++;
          $display("FAIL out_valid cyc=%0d got=%0d want=%0d", cyc, out_valid, me.vld);
        end
        checks++;
        if (me.vld) begin
          diff = real'(out_data) - me.ideal;
          if (diff > 2.0 || diff < -2.0) begin
            errors++;
            $display("FAIL out_data cyc=%0d got=%0d want=%0.1f", cyc, out_data, me.ideal);
          end
        end else if (out_data !== '0) begin
          errors++;
          $display("FAIL idle_zero cyc=%0d got=%0d want=0", cyc, out_data);
        end
        $display("txn cyc=%0d vld=%0d out_valid=%0d out_data=%0d ref=%0.1f",
                 cyc, me.vld, out_valid, out_data, me.ideal);
      end else begin
        checks++;
        if (out_valid) begin
          errors++;
          $display("FAIL unexpected_valid cyc=%0d got=1 want=0", cyc);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_I = '0; in_Q = '0;
    phase_sync = 1'b0; frequency = 32'd0;
    repeat (3) @(negedge clock);
    check_eq("por_valid", int'(out_valid), 0);
    check_eq("por_data", int'(out_data), 0);
    reset_n = 1'b1;

    // DC
    drive(0, 0, 0, 1, 32'd0);
    repeat (30) drive(1, 16384, 0, 0, 32'd0);
    // fs/4 tone
    drive(0, 0, 0, 1, 32'h4000_0000);
    repeat (30) drive(1, 16384, 0, 0, 32'h4000_0000);
    // valid gating
    for (int k = 0; k < 24; k++) drive(k % 2 == 0, 16384, 0, 0, 32'd0);
    // saturation at pi/4
    drive(0, 0, 0, 1, 32'd0);
    drive(0, 0, 0, 0, 32'h2000_0000);
    repeat (24) drive(1, 32767, -32767, 0, 32'd0);
    // extreme frequencies with most-negative I
    drive(0, 0, 0, 1, 32'd0);
    repeat (24) drive(1, -32768, 0, 0, 32'h7FFF_FFFF);
    drive(0, 0, 0, 1, 32'd0);
    repeat (24) drive(1, -32768, 0, 0, 32'h8000_0000);
    // simultaneous sync and valid
    drive(1, 20000, -5000, 1, 32'h1234_5678);
    drive(1, 20000, -5000, 0, 32'h1234_5678);
    // randomized traffic
    for (int k = 0; k < 300; k++) begin
      int ri, rq;
      ri = int'($urandom_range(65535)) - 32768;
      rq = int'($urandom_range(65535)) - 32768;
      drive($urandom_range(3) != 0, ri, rq, $urandom_range(15) == 0, $urandom());
    end
    // reset mid-stream, then restart
    for (int k = 0; k < 10; k++) drive(1, 16384, 0, 0, 32'h0100_0000);
    reset_midstream();
    for (int k = 0; k < 30; k++) drive(1, 12000, 3000, 0, 32'h0300_0000);
    repeat (LAT + 5) drive(0, 0, 0, 0, 32'd0);
    for (int k = 0; k < LAT + 10 && sb.size() > 0; k++) @(negedge clock);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d want=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
